// File: rtl/mux_nway_stream.sv
// N-way valid/ready stream multiplexer with a single registered output stage.
// Selection is either fixed (external sel) or round-robin among valid inputs.
// The rotating pointer restarts the search just past the last round-robin winner.
// Grant and in_ready are combinational from the current cycle's inputs.
// Data and channel index are registered together with out_valid.

module mux_nway_stream #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    // One extra bit so that ptr + offset never overflows before the wrap subtraction.
    localparam logic [SEL_W:0]   CH_L = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    // Output register and arbitration state
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_rr_ptr;

    // Grant path
    logic             w_load;
    logic             w_fix_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_grant_data;
    logic [SEL_W-1:0] w_rr_next;

    // The output register can take a new word when empty or when its word leaves this cycle.
    assign w_load = !r_out_valid || out_ready;

    // Fixed mode: compare sel against every legal index so an out-of-range sel never grants.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_fix_valid = 1'b1;
            end
        end
    end

    // Round-robin: first valid channel found walking forward from the pointer, with wrap.
    always_comb begin
        logic [SEL_W:0] w_cand;
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
            if (w_cand >= CH_L) begin
                w_cand = w_cand - CH_L;
            end
            if (!w_rr_valid && in_valid[w_cand[SEL_W-1:0]]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = w_cand[SEL_W-1:0];
            end
        end
    end

    // Pick the active arbiter's result; mode changes take effect on this cycle's grant.
    always_comb begin
        if (mode) begin
            w_grant_valid = w_rr_valid;
            w_grant_idx   = w_rr_idx;
        end else begin
            w_grant_valid = w_fix_valid;
            w_grant_idx   = sel;
        end
    end

    assign w_xfer = w_grant_valid && w_load;

    // One-hot ready for the granted channel; held low throughout reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && w_xfer && (w_grant_idx == SEL_W'(i));
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap keeps non-power-of-2 counts in range.
    assign w_rr_next = (w_grant_idx == LAST) ? '0 : w_grant_idx + SEL_W'(1);

    // Output stage: load on transfer, drain when consumed with nothing new, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_grant_data;
            r_out_valid <= 1'b1;
            r_out_chan  <= w_grant_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances only on round-robin transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && mode) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_nway_stream.sv
// Testbench for mux_nway_stream: vector table, hand-written corner sequences,
// a CHANNELS=3 instance, and a randomized run against a behavioural model.

module tb_mux_nway_stream;

    localparam int W  = 16;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     ch_data [CH];
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [1:0]      sel;
    logic            mode;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_chan;

    logic [47:0]     in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [1:0]      sel3;
    logic            mode3;
    logic [15:0]     out_data3;
    logic            out_valid3;
    logic            out_ready3;
    logic [1:0]      out_chan3;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int c = 0; c < CH; c++) in_data[c*W +: W] = ch_data[c];
    end

    mux_nway_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    mux_nway_stream #(.WIDTH(16), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .mode      (mode3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_chan  (out_chan3)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        rst_before;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [15:0] exp_data;
        logic [1:0]  exp_chan;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic        m_valid;
    logic [15:0] m_data;
    int          m_chan;
    int          m_ptr;

    function automatic int model_grant(input logic m, input int s, input logic [3:0] v,
                                       input int ptr);
        if (!m) return (s < CH && v[s]) ? s : -1;
        for (int k = 0; k < CH; k++) begin
            int j = (ptr + k) % CH;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          g;
        logic        ld;
        logic [3:0]  exp_rdy;
        logic [15:0] word;

        ch_data[0] = 16'h1234;
        ch_data[1] = 16'h9876;
        ch_data[2] = 16'hAAAA;
        ch_data[3] = 16'h5555;
        in_valid   = 4'hF;
        mode       = 1'b1;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data3   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        in_valid3  = 3'b111;
        sel3       = 2'd3;
        mode3      = 1'b0;
        out_ready3 = 1'b1;

        // Reset held with all inputs valid
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_chan", out_chan, 0);
        check("reset in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 4'b0001);
        @(posedge clk);
        #1;
        check("first grant out_valid", out_valid, 1);
        check("first grant out_chan", out_chan, 0);
        check("first grant out_data", out_data, 16'h1234);

        // rst, mode, sel, vld, ordy, exp_rdy, exp_ov, exp_data, exp_chan
        tbl.push_back('{1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h1234, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 16'hAAAA, 2'd2});
        tbl.push_back('{1'b0, 1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 16'h5555, 2'd3});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h1234, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 16'hAAAA, 2'd2});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 16'h5555, 2'd3});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h1234, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 16'h5555, 2'd3});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 16'h5555, 2'd3});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 16'h9876, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 16'h9876, 2'd1});

        foreach (tbl[k]) begin
            if (tbl[k].rst_before) do_reset();
            mode      = tbl[k].mode;
            sel       = tbl[k].sel;
            in_valid  = tbl[k].vld;
            out_ready = tbl[k].ordy;
            #1;
            check($sformatf("row%0d in_ready", k), in_ready, tbl[k].exp_rdy);
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_valid", k), out_valid, tbl[k].exp_ov);
            check($sformatf("row%0d out_data", k), out_data, tbl[k].exp_data);
            check($sformatf("row%0d out_chan", k), out_chan, tbl[k].exp_chan);
        end

        // Backpressure while holding 0x9876, then drain and fill on the same edge
        mode      = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp load out_data", out_data, 16'h9876);
        ch_data[1] = 16'h1111;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d in_ready", i), in_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out_valid", i), out_valid, 1);
            check($sformatf("bp%0d out_data", i), out_data, 16'h9876);
            check($sformatf("bp%0d out_chan", i), out_chan, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 4'b0010);
        @(posedge clk);
        #1;
        check("bp release out_valid", out_valid, 1);
        check("bp release out_data", out_data, 16'h1111);

        // CHANNELS=3: sel=3 is out of range and never grants
        check("ch3 sel3 in_ready", in_ready3, 0);
        check("ch3 sel3 out_valid", out_valid3, 0);
        sel3 = 2'd2;
        #1;
        check("ch3 sel2 in_ready", in_ready3, 3'b100);
        @(posedge clk);
        #1;
        check("ch3 sel2 out_data", out_data3, 16'hCCCC);
        check("ch3 sel2 out_chan", out_chan3, 2);
        // Round-robin wrap with ch0 and ch2 valid: 0, 2, 0
        mode3     = 1'b1;
        in_valid3 = 3'b101;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ch3 rr%0d out_chan", i), out_chan3, (i == 1) ? 2 : 0);
        end

        // Randomized run against the behavioural model
        in_valid = 4'h0;
        do_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(7) == 0) mode = ~mode;
            if ($urandom_range(3) == 0) sel = 2'($urandom_range(3));
            out_ready = ($urandom_range(9) < 7);
            for (int c = 0; c < CH; c++) begin
                if (!in_valid[c] && $urandom_range(1) == 1) begin
                    in_valid[c] = 1'b1;
                    ch_data[c]  = 16'($urandom);
                end
            end
            #1;
            g       = model_grant(mode, int'(sel), in_valid, m_ptr);
            ld      = !m_valid || out_ready;
            exp_rdy = (g >= 0 && ld) ? 4'(1 << g) : 4'h0;
            word    = (g >= 0) ? ch_data[g] : 16'h0;
            check($sformatf("rand%0d in_ready", cyc), in_ready, exp_rdy);
            @(posedge clk);
            #1;
            if (exp_rdy != 0) begin
                m_valid     = 1'b1;
                m_data      = word;
                m_chan      = g;
                if (mode) m_ptr = (g + 1) % CH;
                in_valid[g] = 1'b0;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            check($sformatf("rand%0d out_valid", cyc), out_valid, m_valid);
            check($sformatf("rand%0d out_data", cyc), out_data, m_data);
            check($sformatf("rand%0d out_chan", cyc), out_chan, m_chan);
        end

        // Asynchronous reset while a word is held
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre-async out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async out_data", out_data, 0);
        check("async in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
